// File: rtl/apb_slave_regs_if.sv
// APB bus bundle between the team's APB master and the register-bank completer.
interface apb_slave_regs_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_regs.sv
// APB completer with a read-only ID word at offset 0 and NUM_REGS-1 read/write
// 32-bit registers; inserts WAIT_STATES access-phase wait cycles before PREADY.
module apb_slave_regs #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA0B0_0001
) (
  input logic             PCLK,
  input logic             PRESETn,
  apb_slave_regs_if.slave apb
);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic        ready_q;
  logic        slverr_q;
  logic [31:0] rdata_q;
  logic [31:0] regs [1:NUM_REGS-1];

  logic [31:0] cur_addr;
  logic        cur_write;
  logic [3:0]  cur_idx;
  logic        cur_err;
  logic [31:0] cur_rdata;

  // Decode looks at the live bus in IDLE so a zero-wait build can answer
  // straight out of the setup edge; in ACCESS it uses the latched request.
  always_comb begin
    cur_addr  = (state == S_IDLE) ? apb.PADDR  : addr_q;
    cur_write = (state == S_IDLE) ? apb.PWRITE : write_q;
    cur_idx   = cur_addr[5:2];
    cur_err   = (cur_addr[1:0] != 2'b00) ||
                (cur_addr >= 32'(4 * NUM_REGS)) ||
                (cur_write && (cur_idx == 4'd0));
    cur_rdata = '0;
    if (cur_idx == 4'd0) begin
      cur_rdata = ID_VALUE;
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (32'(cur_idx) == i) cur_rdata = regs[i];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
      case (state)
        S_IDLE: begin
          if (apb.PSEL && !apb.PENABLE) begin
            addr_q  <= apb.PADDR;
            wdata_q <= apb.PWDATA;
            write_q <= apb.PWRITE;
            cnt     <= 4'(WAIT_STATES);
            state   <= S_ACCESS;
            if (WAIT_STATES == 0) begin
              ready_q  <= 1'b1;
              slverr_q <= cur_err;
              rdata_q  <= (!cur_write && !cur_err) ? cur_rdata : '0;
            end
          end
        end
        S_ACCESS: begin
          if (ready_q) begin
            // Commit happens on the edge that closes the PREADY cycle.
            if (write_q && !cur_err) begin
              for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (32'(cur_idx) == i) regs[i] <= wdata_q;
              end
            end
            cnt   <= '0;
            state <= S_IDLE;
          end else if (!apb.PSEL) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              ready_q  <= 1'b1;
              slverr_q <= cur_err;
              rdata_q  <= (!write_q && !cur_err) ? cur_rdata : '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign apb.PREADY  = ready_q;
  assign apb.PSLVERR = slverr_q;
  assign apb.PRDATA  = rdata_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Drives one APB master onto three completers (0, 1 and 3 wait states) in
// parallel and checks every access cycle against a register-array model.
module tb_apb_slave_regs;

  localparam int          NREG = 8;
  localparam logic [31:0] IDV  = 32'hA0B0_0001;
  localparam int          WS [3] = '{0, 1, 3};
  localparam int          SPAN = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;

  logic        rdy  [3];
  logic        serr [3];
  logic [31:0] rdat [3];

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model [3][NREG];

  always #5 clk = ~clk;

  apb_slave_regs_if bus0 ();
  apb_slave_regs_if bus1 ();
  apb_slave_regs_if bus2 ();

  assign bus0.PSEL = psel;    assign bus1.PSEL = psel;    assign bus2.PSEL = psel;
  assign bus0.PENABLE = penable; assign bus1.PENABLE = penable; assign bus2.PENABLE = penable;
  assign bus0.PWRITE = pwrite;  assign bus1.PWRITE = pwrite;  assign bus2.PWRITE = pwrite;
  assign bus0.PADDR = paddr;   assign bus1.PADDR = paddr;   assign bus2.PADDR = paddr;
  assign bus0.PWDATA = pwdata;  assign bus1.PWDATA = pwdata;  assign bus2.PWDATA = pwdata;

  assign rdy[0] = bus0.PREADY;  assign serr[0] = bus0.PSLVERR;  assign rdat[0] = bus0.PRDATA;
  assign rdy[1] = bus1.PREADY;  assign serr[1] = bus1.PSLVERR;  assign rdat[1] = bus1.PRDATA;
  assign rdy[2] = bus2.PREADY;  assign serr[2] = bus2.PSLVERR;  assign rdat[2] = bus2.PRDATA;

  apb_slave_regs #(.NUM_REGS(NREG), .WAIT_STATES(0), .ID_VALUE(IDV)) u_w0 (
    .PCLK(clk), .PRESETn(rstn), .apb(bus0.slave));
  apb_slave_regs #(.NUM_REGS(NREG), .WAIT_STATES(1), .ID_VALUE(IDV)) u_w1 (
    .PCLK(clk), .PRESETn(rstn), .apb(bus1.slave));
  apb_slave_regs #(.NUM_REGS(NREG), .WAIT_STATES(3), .ID_VALUE(IDV)) u_w3 (
    .PCLK(clk), .PRESETn(rstn), .apb(bus2.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic void predict(input int d, input logic [31:0] a, input logic w,
                                  output logic e, output logic [31:0] rd);
    e  = (a % 4 != 0) || (a >= 4 * NREG) || (w && a == 0);
    rd = 32'h0;
    if (!w && !e) rd = (a == 0) ? IDV : model[d][a / 4];
  endfunction

  // One APB transfer. drop_at / rst_at: access cycle in which PSEL is
  // removed / PRESETn is low (0 = never). Access phase lasts SPAN cycles so
  // the slowest completer finishes; faster ones sit in IDLE meanwhile.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic w,
                      input int drop_at, input int rst_at);
    logic        e   [3];
    logic [31:0] rd  [3];
    logic        vis [3];
    int          r;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = a; pwdata = wd; pwrite = w;
    for (int d = 0; d < 3; d++) begin
      predict(d, a, w, e[d], rd[d]);
      r = 1 + WS[d];
      vis[d] = (drop_at == 0 || drop_at >= r) && (rst_at == 0 || rst_at >= r);
    end
    @(posedge clk);
    for (int k = 1; k <= SPAN; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (vis[d] && k == 1 + WS[d]) begin
          check($sformatf("w%0d_ready_a%0h", WS[d], a), 32'(rdy[d]), 32'h1);
          check($sformatf("w%0d_slverr_a%0h", WS[d], a), 32'(serr[d]), 32'(e[d]));
          check($sformatf("w%0d_prdata_a%0h", WS[d], a), rdat[d], rd[d]);
        end else begin
          check($sformatf("w%0d_noready_k%0d_a%0h", WS[d], k, a), 32'(rdy[d]), 32'h0);
          check($sformatf("w%0d_idle_data_k%0d", WS[d], k),
                {serr[d], rdat[d][30:0]} | {1'b0, rdat[d][31], 30'h0}, 32'h0);
        end
      end
      penable = 1'b1;
      paddr   = $urandom;
      pwdata  = $urandom;
      pwrite  = 1'($urandom);
      if (k == drop_at) psel = 1'b0;
      rstn = (k == rst_at) ? 1'b0 : 1'b1;
      @(posedge clk);
    end
    for (int d = 0; d < 3; d++)
      if (w && !e[d] && vis[d] && rst_at == 0) model[d][a / 4] = wd;
    if (rst_at != 0)
      for (int d = 0; d < 3; d++)
        for (int i = 0; i < NREG; i++) model[d][i] = 32'h0;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: rand_addr = 32'($urandom_range(0, NREG - 1)) * 4;
      3:       rand_addr = 32'h0;
      4:       rand_addr = 32'($urandom_range(0, NREG - 1)) * 4 + 32'($urandom_range(1, 3));
      default: rand_addr = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(4 * NREG, 63))
                                                       : ($urandom | 32'h100);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < NREG; i++) model[d][i] = 32'h0;
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("w%0d_rst_ready", WS[d]), 32'(rdy[d]), 32'h0);
      check($sformatf("w%0d_rst_slverr", WS[d]), 32'(serr[d]), 32'h0);
      check($sformatf("w%0d_rst_prdata", WS[d]), rdat[d], 32'h0);
    end
    rstn = 1'b1;
    @(posedge clk);

    // ID and reset contents
    xfer(32'h00, 32'h0, 1'b0, 0, 0);
    xfer(32'h04, 32'h0, 1'b0, 0, 0);
    // plain write/readback
    xfer(32'h08, 32'hDEADBEEF, 1'b1, 0, 0);
    xfer(32'h08, 32'h0, 1'b0, 0, 0);
    // ID is read-only
    xfer(32'h00, 32'h12345678, 1'b1, 0, 0);
    xfer(32'h00, 32'h0, 1'b0, 0, 0);
    // out of range / unaligned
    xfer(32'h20, 32'h0, 1'b0, 0, 0);
    xfer(32'h06, 32'h0, 1'b0, 0, 0);
    xfer(32'h21, 32'hFFFFFFFF, 1'b1, 0, 0);
    idle(2);
    for (int i = 0; i < NREG; i++) xfer(32'(i * 4), 32'h0, 1'b0, 0, 0);
    xfer(32'h0C, 32'h0000A5A5, 1'b1, 0, 0);
    xfer(32'h0C, 32'h0, 1'b0, 0, 0);
    idle(1);
    // reset during a transfer, then an aborted transfer
    xfer(32'h04, 32'h55, 1'b1, 0, 2);
    xfer(32'h04, 32'h0, 1'b0, 0, 0);
    xfer(32'h04, 32'h55, 1'b1, 2, 0);
    idle(1);
    xfer(32'h04, 32'h0, 1'b0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      xfer(rand_addr(), $urandom, 1'($urandom), 0, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    for (int i = 0; i < NREG; i++) xfer(32'(i * 4), 32'h0, 1'b0, 0, 0);

    idle(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
